// File: rtl/ftdi_send_arbiter_pkg.sv
// rtl/ftdi_send_arbiter_pkg.sv - shared types and constants for the FTDI send arbiter
package ftdi_send_arb_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StLock = 1'b1
    } ArbState;

    localparam logic [9:0] CTimeOutDef = 10'd1000;

    // Smallest index width able to address n requesters.
    function automatic int idxLen(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ftdi_send_arbiter_if.sv
// rtl/ftdi_send_arbiter_if.sv - requester lanes and send FIFO write port bundle
interface ftdi_send_arbiter_if #(
    parameter int CReqCnt = 4
);
    logic [CReqCnt-1:0]   AReqValid;
    logic [CReqCnt*8-1:0] AReqData;
    logic [CReqCnt-1:0]   AReqLast;
    logic [CReqCnt-1:0]   AReqReady;
    logic                 ASendHasSpace;
    logic [7:0]           ASendData;
    logic                 ASendNow;

    modport master (
        output AReqValid, AReqData, AReqLast, ASendHasSpace,
        input  AReqReady, ASendData, ASendNow
    );

    modport slave (
        input  AReqValid, AReqData, AReqLast, ASendHasSpace,
        output AReqReady, ASendData, ASendNow
    );
endinterface

// File: rtl/ftdi_send_arbiter_rr_pick.sv
// rtl/ftdi_send_arbiter_rr_pick.sv - combinational round-robin picker, first request after ALastIdx
module MsRrPick
    import ftdi_send_arb_pkg::*;
#(
    parameter int CReqCnt = 4,
    parameter int CIdxLen = 3
) (
    input  logic [CReqCnt-1:0] AReq,
    input  logic [CIdxLen-1:0] ALastIdx,
    output logic [CIdxLen-1:0] AIdx,
    output logic               AFound
);

    int cand;

    // Scan from the farthest offset down so the nearest valid index overwrites last.
    always_comb begin
        AIdx   = '0;
        AFound = 1'b0;
        cand   = 0;
        for (int k = CReqCnt; k >= 1; k--) begin
            cand = int'(ALastIdx) + k;
            if (cand >= CReqCnt) cand = cand - CReqCnt;
            if (AReq[cand]) begin
                AIdx   = CIdxLen'(cand);
                AFound = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ftdi_send_arbiter.sv
// rtl/ftdi_send_arbiter.sv - packet-locked round-robin arbiter for the FTDI send FIFO
// Optional lock-idle timeout: FTDI_SEND_ARB_TIMEOUT_EN.
module ftdi_send_arbiter
    import ftdi_send_arb_pkg::*;
#(
    parameter int         CReqCnt  = 4,
    parameter int         CIdxLen  = 3,
    parameter logic [9:0] CTimeOut = CTimeOutDef
) (
    input  logic               AClkH,
    input  logic               AResetHN,
    input  logic               AClkHEn,
    input  logic               ASync1K,
    ftdi_send_arbiter_if.slave AIf,
    output logic               ABusy,
    output logic [CIdxLen-1:0] AGrantIdx,
    output logic               AAbort,
    output logic [CIdxLen-1:0] AAbortIdx
);

    ArbState             FState, wNextState;
    logic [CIdxLen-1:0]  FGrant, FLastIdx, wPickIdx;
    logic [7:0]          FSendData;
    logic                FSendNow, FBusy;
    logic                wFound, wAccept, wTimeout, wLockEntry;
    logic [CReqCnt-1:0]  wReady;

    MsRrPick #(.CReqCnt(CReqCnt), .CIdxLen(CIdxLen)) uPick (
        .AReq     (AIf.AReqValid),
        .ALastIdx (FLastIdx),
        .AIdx     (wPickIdx),
        .AFound   (wFound)
    );

    assign wLockEntry = (FState == StIdle) && wFound;

    // Holding off while a write is in flight keeps ASendHasSpace current.
    always_comb begin
        wReady  = '0;
        wAccept = 1'b0;
        if (AClkHEn && FState == StLock && AIf.AReqValid[FGrant] &&
            AIf.ASendHasSpace && !FSendNow) begin
            wReady[FGrant] = 1'b1;
            wAccept        = 1'b1;
        end
    end

    always_comb begin
        wNextState = FState;
        case (FState)
            StIdle:  if (wFound) wNextState = StLock;
            StLock:  if ((wAccept && AIf.AReqLast[FGrant]) || wTimeout) wNextState = StIdle;
            default: wNextState = StIdle;
        endcase
    end

    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            FState    <= StIdle;
            FGrant    <= '0;
            FLastIdx  <= CIdxLen'(CReqCnt - 1);
            FSendData <= '0;
            FSendNow  <= 1'b0;
            FBusy     <= 1'b0;
        end else if (AClkHEn) begin
            FState   <= wNextState;
            FSendNow <= wAccept;
            FBusy    <= (wNextState == StLock) || wAccept;
            if (wLockEntry) FGrant <= wPickIdx;
            if (wAccept) FSendData <= AIf.AReqData[int'(FGrant)*8 +: 8];
            if ((wAccept && AIf.AReqLast[FGrant]) || wTimeout) FLastIdx <= FGrant;
        end
    end

`ifdef FTDI_SEND_ARB_TIMEOUT_EN
    logic [9:0]         FTimer;
    logic               FAbort;
    logic [CIdxLen-1:0] FAbortIdx;

    assign wTimeout = (FState == StLock) && (FTimer == '0) && !AIf.AReqValid[FGrant];

    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            FTimer    <= '0;
            FAbort    <= 1'b0;
            FAbortIdx <= '0;
        end else if (AClkHEn) begin
            FAbort <= wTimeout;
            if (wTimeout) FAbortIdx <= FGrant;
            if (wLockEntry || wAccept) FTimer <= CTimeOut;
            else if (ASync1K && FTimer != '0) FTimer <= FTimer - 10'd1;
        end
    end

    assign AAbort    = FAbort;
    assign AAbortIdx = FAbortIdx;
`else
    logic unusedSync;
    assign unusedSync = ASync1K ^ (|CTimeOut);
    assign wTimeout   = 1'b0;
    assign AAbort     = 1'b0;
    assign AAbortIdx  = '0;
`endif

    assign AIf.AReqReady = wReady;
    assign AIf.ASendData = FSendData;
    assign AIf.ASendNow  = FSendNow;
    assign ABusy         = FBusy;
    assign AGrantIdx     = FGrant;

endmodule

// File: tb/tb_ftdi_send_arbiter.sv
// tb/tb_ftdi_send_arbiter.sv - scoreboard bench for the FTDI send arbiter
module tb_ftdi_send_arbiter;

    localparam int N = 4;

    logic       AClkH    = 1'b0;
    logic       AResetHN = 1'b0;
    logic       AClkHEn  = 1'b1;
    logic       ASync1K  = 1'b0;
    logic       ABusy, AAbort;
    logic [2:0] AGrantIdx, AAbortIdx;

    ftdi_send_arbiter_if #(.CReqCnt(N)) bus ();

    ftdi_send_arbiter #(.CReqCnt(N), .CIdxLen(3)) dut (
        .AClkH     (AClkH),
        .AResetHN  (AResetHN),
        .AClkHEn   (AClkHEn),
        .ASync1K   (ASync1K),
        .AIf       (bus),
        .ABusy     (ABusy),
        .AGrantIdx (AGrantIdx),
        .AAbort    (AAbort),
        .AAbortIdx (AAbortIdx)
    );

    always #5 AClkH = ~AClkH;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          writeCount = 0;
    int          lastWr = -10;
    int          prevWr = -10;
    int          abortCount = 0;
    int          base;
    logic [2:0]  lastAbortIdx = '0;
    logic [10:0] expQ[$];
    logic [8:0]  reqQ[N][$];
    logic [N-1:0] rdy;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic req(input int r, input logic [7:0] d, input logic last);
        reqQ[r].push_back({last, d});
    endtask

    task automatic exp(input int r, input logic [7:0] d);
        expQ.push_back({3'(r), d});
    endtask

    task automatic tick();
        @(posedge AClkH);
        #1;
    endtask

    task automatic doReset();
        AResetHN = 1'b0;
        for (int i = 0; i < N; i++) reqQ[i].delete();
        repeat (3) tick();
        AResetHN = 1'b1;
    endtask

    task automatic waitWrites(input int n, input int budget);
        for (int k = 0; k < budget && writeCount < n; k++) tick();
        check("wait_write", int'(writeCount >= n), 1);
    endtask

    task automatic waitIdle(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            tick();
            done = (expQ.size() == 0) && (bus.AReqValid == '0) && !ABusy;
        end
        check("drain_idle", int'(done), 1);
    endtask

    always @(posedge AClkH) cycle <= cycle + 1;

    // Requester model: present queue heads, pop on an accepted byte.
    initial begin
        bus.AReqValid = '0;
        bus.AReqData  = '0;
        bus.AReqLast  = '0;
        forever begin
            @(negedge AClkH);
            rdy = bus.AReqReady;
            @(posedge AClkH);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rdy[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
                if (reqQ[i].size() > 0) begin
                    bus.AReqValid[i]        = 1'b1;
                    bus.AReqData[i*8 +: 8]  = reqQ[i][0][7:0];
                    bus.AReqLast[i]         = reqQ[i][0][8];
                end else begin
                    bus.AReqValid[i]        = 1'b0;
                    bus.AReqData[i*8 +: 8]  = 8'h00;
                    bus.AReqLast[i]         = 1'b0;
                end
            end
        end
    end

    always @(negedge AClkH) begin
        logic [10:0] e;
        if (AResetHN && bus.ASendNow) begin
            if (expQ.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = expQ.pop_front();
                check("write_data", int'(bus.ASendData), int'(e[7:0]));
                check("write_src", int'(AGrantIdx), int'(e[10:8]));
            end
            check("write_spacing", int'(cycle - lastWr >= 2), 1);
            prevWr = lastWr;
            lastWr = cycle;
            writeCount++;
        end
        if (AAbort) begin
            abortCount++;
            lastAbortIdx = AAbortIdx;
        end
    end

    initial begin
        bus.ASendHasSpace = 1'b1;
        repeat (3) tick();
        check("rst_senddata", int'(bus.ASendData), 0);
        check("rst_sendnow", int'(bus.ASendNow), 0);
        check("rst_busy", int'(ABusy), 0);
        check("rst_grant", int'(AGrantIdx), 0);
        check("rst_abort", int'(AAbort), 0);
        check("rst_abortidx", int'(AAbortIdx), 0);
        check("rst_ready", int'(bus.AReqReady), 0);
        AResetHN = 1'b1;
        tick();

        // single requester, two bytes
        req(1, 8'h55, 1'b0); req(1, 8'hAA, 1'b1);
        exp(1, 8'h55); exp(1, 8'hAA);
        waitIdle(50);
        check("t1_gap", lastWr - prevWr, 2);
        check("t1_busy", int'(ABusy), 0);

        // clock enable low freezes everything
        AClkHEn = 1'b0;
        base = writeCount;
        req(1, 8'h11, 1'b1); exp(1, 8'h11);
        repeat (10) begin
            tick();
            check("en_ready", int'(bus.AReqReady), 0);
        end
        check("en_busy", int'(ABusy), 0);
        check("en_writes", writeCount, base);
        AClkHEn = 1'b1;
        waitIdle(50);

        // no interleaving; late requester 1 joins the rotation after 0
        doReset();
        req(0, 8'h01, 1'b0); req(0, 8'h02, 1'b0); req(0, 8'h03, 1'b0); req(0, 8'h04, 1'b1);
        req(2, 8'h21, 1'b0); req(2, 8'h22, 1'b1);
        exp(0, 8'h01); exp(0, 8'h02); exp(0, 8'h03); exp(0, 8'h04);
        exp(1, 8'h11); exp(1, 8'h12);
        exp(2, 8'h21); exp(2, 8'h22);
        repeat (3) tick();
        req(1, 8'h11, 1'b0); req(1, 8'h12, 1'b1);
        waitIdle(200);

        // round robin with one-byte packets
        doReset();
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < 3; r++) begin
                req(r, 8'(8'h40 + rep * 16 + r), 1'b1);
                exp(r, 8'(8'h40 + rep * 16 + r));
            end
        waitIdle(200);

        // FIFO full mid-packet
        doReset();
        base = writeCount;
        req(1, 8'hA1, 1'b0); req(1, 8'hA2, 1'b0); req(1, 8'hA3, 1'b0); req(1, 8'hA4, 1'b1);
        exp(1, 8'hA1); exp(1, 8'hA2); exp(1, 8'hA3); exp(1, 8'hA4);
        waitWrites(base + 2, 50);
        bus.ASendHasSpace = 1'b0;
        repeat (2) tick();
        base = writeCount;
        repeat (18) begin
            tick();
            check("nospace_ready", int'(bus.AReqReady), 0);
        end
        check("nospace_writes", writeCount, base);
        check("nospace_busy", int'(ABusy), 1);
        bus.ASendHasSpace = 1'b1;
        waitIdle(100);
        check("nospace_total", writeCount, base + 2);

        // idle lock on requester 3
        doReset();
        base = writeCount;
        req(3, 8'h3A, 1'b0); exp(3, 8'h3A);
        waitWrites(base + 1, 50);
        req(0, 8'h0B, 1'b1);
`ifdef FTDI_SEND_ARB_TIMEOUT_EN
        exp(0, 8'h0B);
        repeat (999) begin
            ASync1K = 1'b1; tick();
            ASync1K = 1'b0; tick();
        end
        check("to_early_abort", abortCount, 0);
        check("to_held_writes", writeCount, base + 1);
        check("to_held_busy", int'(ABusy), 1);
        ASync1K = 1'b1; tick();
        ASync1K = 1'b0;
        repeat (4) tick();
        check("to_abort_count", abortCount, 1);
        check("to_abort_idx", int'(lastAbortIdx), 3);
        waitIdle(50);
`else
        repeat (50) begin
            ASync1K = 1'b1; tick();
            ASync1K = 1'b0; tick();
        end
        check("hold_busy", int'(ABusy), 1);
        check("hold_grant", int'(AGrantIdx), 3);
        check("hold_writes", writeCount, base + 1);
        req(3, 8'h3C, 1'b1);
        exp(3, 8'h3C); exp(0, 8'h0B);
        waitIdle(50);
`endif

        // reset mid-packet
        base = writeCount;
        req(2, 8'hC1, 1'b0); req(2, 8'hC2, 1'b0); req(2, 8'hC3, 1'b0); req(2, 8'hC4, 1'b1);
        exp(2, 8'hC1);
        waitWrites(base + 1, 50);
        AResetHN = 1'b0;
        for (int i = 0; i < N; i++) reqQ[i].delete();
        #1;
        check("mid_rst_sendnow", int'(bus.ASendNow), 0);
        check("mid_rst_senddata", int'(bus.ASendData), 0);
        check("mid_rst_busy", int'(ABusy), 0);
        check("mid_rst_grant", int'(AGrantIdx), 0);
        check("mid_rst_ready", int'(bus.AReqReady), 0);
        check("mid_rst_abort", int'(AAbort), 0);
        repeat (3) tick();
        AResetHN = 1'b1;
        tick();
        req(3, 8'h3D, 1'b1); req(0, 8'h0D, 1'b1);
        exp(0, 8'h0D); exp(3, 8'h3D);
        waitIdle(50);

`ifdef FTDI_SEND_ARB_TIMEOUT_EN
        check("abort_total", abortCount, 1);
`else
        check("abort_total", abortCount, 0);
`endif
        check("exp_empty", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
